line_merge_buffer: RTL and testbench



---
 rtl/line_merge_buffer_pkg.sv | 19 +
 rtl/line_merge_buffer_if.sv | 38 +++
 rtl/line_merge_buffer_word_byte_merge.sv | 30 +++
 rtl/line_merge_buffer.sv | 128 ++++++++++++
 tb/tb_line_merge_buffer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_merge_buffer_pkg.sv
// Shared types and default sizing for the line merge buffer.
// The design headers list the LINE_MERGE_BYTE_STROBE_EN build option.
package line_merge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam int WORD_SIZE_DEF        = 32;
    localparam int NUM_SEGMENTS_DEF     = 16;
    localparam int NUM_SEGMENTS_LOG_DEF = 4;
    localparam int BLOCK_SIZE_DEF       = WORD_SIZE_DEF * NUM_SEGMENTS_DEF;

    localparam int STRB_W    = WORD_SIZE_DEF / 8;
    localparam int COUNT_MAX = (1 << (NUM_SEGMENTS_LOG_DEF + 1)) - 1;

endpackage

// File: rtl/line_merge_buffer_if.sv
// Load / word-write / merged-output handshake bundle for line_merge_buffer.
// The slave modport is the buffer side; the master modport is its user.
interface line_merge_buffer_if
    import line_merge_pkg::*;
#(
    parameter int WORD_SIZE        = WORD_SIZE_DEF,
    parameter int NUM_SEGMENTS     = NUM_SEGMENTS_DEF,
    parameter int NUM_SEGMENTS_LOG = NUM_SEGMENTS_LOG_DEF,
    parameter int BLOCK_SIZE       = WORD_SIZE * NUM_SEGMENTS
) ();

    logic                        ld_valid;
    logic                        ld_ready;
    logic [BLOCK_SIZE-1:0]       ld_data;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [NUM_SEGMENTS_LOG-1:0] wr_offset;
    logic [WORD_SIZE-1:0]        wr_data;
    logic [WORD_SIZE/8-1:0]      wr_strb;
    logic                        wr_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [BLOCK_SIZE-1:0]       out_data;
    logic [NUM_SEGMENTS-1:0]     out_dirty;
    logic [NUM_SEGMENTS_LOG:0]   out_wr_count;
    logic                        out_err;

    modport master (
        output ld_valid, ld_data, wr_valid, wr_offset, wr_data, wr_strb, wr_last, out_ready,
        input  ld_ready, wr_ready, out_valid, out_data, out_dirty, out_wr_count, out_err
    );

    modport slave (
        input  ld_valid, ld_data, wr_valid, wr_offset, wr_data, wr_strb, wr_last, out_ready,
        output ld_ready, wr_ready, out_valid, out_data, out_dirty, out_wr_count, out_err
    );

endinterface

// File: rtl/line_merge_buffer_word_byte_merge.sv
// Combinational byte merge of one addressed word with incoming write data.
// LINE_MERGE_BYTE_STROBE_EN: honour strobes; otherwise the new word replaces the old.
module word_byte_merge #(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0]   i_old,
    input  logic [WORD_SIZE-1:0]   i_new,
    input  logic [WORD_SIZE/8-1:0] i_strb,
    output logic [WORD_SIZE-1:0]   o_word
);

`ifdef LINE_MERGE_BYTE_STROBE_EN
    // Per-byte select between the stored and the written byte
    always_comb begin
        o_word = i_old;
        for (int b = 0; b < WORD_SIZE / 8; b++) begin
            if (i_strb[b]) begin
                o_word[8*b +: 8] = i_new[8*b +: 8];
            end else begin
                o_word[8*b +: 8] = i_old[8*b +: 8];
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_old, i_strb};
    assign o_word   = i_new;
`endif

endmodule

// File: rtl/line_merge_buffer.sv
// Block merge buffer: load a line, apply offset/strobe word writes, hand out the merged line.
// LINE_MERGE_BYTE_STROBE_EN enables per-byte strobes in the word merge.
module line_merge_buffer
    import line_merge_pkg::*;
#(
    parameter int WORD_SIZE        = WORD_SIZE_DEF,
    parameter int NUM_SEGMENTS     = NUM_SEGMENTS_DEF,
    parameter int NUM_SEGMENTS_LOG = NUM_SEGMENTS_LOG_DEF,
    parameter int BLOCK_SIZE       = WORD_SIZE * NUM_SEGMENTS
) (
    input  logic              clk,
    input  logic              rst,
    line_merge_buffer_if.slave bus
);

    localparam logic [NUM_SEGMENTS_LOG:0] SEG_LIMIT = (NUM_SEGMENTS_LOG + 1)'(NUM_SEGMENTS);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_ld_ready;
    logic                        r_wr_ready;
    logic                        r_out_valid;
    logic [WORD_SIZE-1:0]        r_line [NUM_SEGMENTS];
    logic [NUM_SEGMENTS-1:0]     r_dirty;
    logic [NUM_SEGMENTS_LOG:0]   r_count;
    logic                        r_err;

    logic                        w_load;
    logic                        w_wr;
    logic                        w_in_range;
    logic [NUM_SEGMENTS_LOG-1:0] w_sel;
    logic [WORD_SIZE-1:0]        w_old;
    logic [WORD_SIZE-1:0]        w_merged;

    // Handshake qualifiers and addressed-word mux; out-of-range offsets read word 0 harmlessly
    always_comb begin
        w_load     = (r_state == IDLE) && bus.ld_valid;
        w_wr       = (r_state == MERGE) && bus.wr_valid;
        w_in_range = ({1'b0, bus.wr_offset} < SEG_LIMIT);
        if (w_in_range) begin
            w_sel = bus.wr_offset;
        end else begin
            w_sel = '0;
        end
        w_old = r_line[w_sel];
    end

    word_byte_merge #(.WORD_SIZE(WORD_SIZE)) u_merge (
        .i_old  (w_old),
        .i_new  (bus.wr_data),
        .i_strb (bus.wr_strb),
        .o_word (w_merged)
    );

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.ld_valid) w_state_nxt = MERGE; else w_state_nxt = IDLE;
            MERGE:   if (bus.wr_valid && bus.wr_last) w_state_nxt = OUT; else w_state_nxt = MERGE;
            OUT:     if (bus.out_ready) w_state_nxt = IDLE; else w_state_nxt = OUT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; handshake flags are registered copies of the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ld_ready  <= 1'b1;
            r_wr_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ld_ready  <= (w_state_nxt == IDLE);
            r_wr_ready  <= (w_state_nxt == MERGE);
            r_out_valid <= (w_state_nxt == OUT);
        end
    end

    // Line register, dirty map, saturating write count and sticky offset error
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SEGMENTS; k++) begin
                r_line[k] <= '0;
            end
            r_dirty <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            for (int k = 0; k < NUM_SEGMENTS; k++) begin
                r_line[k] <= bus.ld_data[k*WORD_SIZE +: WORD_SIZE];
            end
            r_dirty <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_wr) begin
            for (int k = 0; k < NUM_SEGMENTS; k++) begin
                if (w_in_range && (w_sel == NUM_SEGMENTS_LOG'(k))) begin
                    r_line[k]  <= w_merged;
                    r_dirty[k] <= 1'b1;
                end
            end
            if (!w_in_range) begin
                r_err <= 1'b1;
            end
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Flatten the line register onto the output bus
    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < NUM_SEGMENTS; k++) begin
            bus.out_data[k*WORD_SIZE +: WORD_SIZE] = r_line[k];
        end
    end

    assign bus.ld_ready     = r_ld_ready;
    assign bus.wr_ready     = r_wr_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_dirty    = r_dirty;
    assign bus.out_wr_count = r_count;
    assign bus.out_err      = r_err;

endmodule

// File: tb/tb_line_merge_buffer.sv
// Scoreboard bench for line_merge_buffer: 16-word instance for the main flows,
// 12-word instance for out-of-range offsets.
module tb_line_merge_buffer;

`ifdef LINE_MERGE_BYTE_STROBE_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    typedef struct {
        logic [511:0] data;
        logic [15:0]  dirty;
        logic [4:0]   cnt;
        logic         err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    logic [31:0]  m_line [16];
    logic [15:0]  m_dirty;
    logic [4:0]   m_cnt;
    logic [511:0] snap;
    logic [383:0] blk12;
    logic [383:0] e12;

    line_merge_buffer_if #(.WORD_SIZE(32), .NUM_SEGMENTS(16), .NUM_SEGMENTS_LOG(4), .BLOCK_SIZE(512)) bus ();
    line_merge_buffer_if #(.WORD_SIZE(32), .NUM_SEGMENTS(12), .NUM_SEGMENTS_LOG(4), .BLOCK_SIZE(384)) b12 ();

    line_merge_buffer #(.WORD_SIZE(32), .NUM_SEGMENTS(16), .NUM_SEGMENTS_LOG(4), .BLOCK_SIZE(512)) u_dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    line_merge_buffer #(.WORD_SIZE(32), .NUM_SEGMENTS(12), .NUM_SEGMENTS_LOG(4), .BLOCK_SIZE(384)) u_dut12 (
        .clk (clk), .rst (rst), .bus (b12)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] m_pack();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = m_line[k];
        return v;
    endfunction

    function automatic logic [511:0] blk_idx();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = 32'(k);
        return v;
    endfunction

    function automatic logic [511:0] blk_fill(input logic [31:0] w);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = w;
        return v;
    endfunction

    // Scoreboard monitor: every completed output handshake is checked against the queue head
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 512'(bus.out_valid), 512'(1'b0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_out_data", bus.out_data, e.data);
                check("sb_out_dirty", 512'(bus.out_dirty), 512'(e.dirty));
                check("sb_out_wr_count", 512'(bus.out_wr_count), 512'(e.cnt));
                check("sb_out_err", 512'(bus.out_err), 512'(e.err));
            end
        end
    end

    task automatic do_load(input logic [511:0] blk);
        bus.ld_data  = blk;
        bus.ld_valid = 1'b1;
        check("ld_ready", 512'(bus.ld_ready), 512'(1'b1));
        tick();
        bus.ld_valid = 1'b0;
        for (int k = 0; k < 16; k++) m_line[k] = blk[k*32 +: 32];
        m_dirty = 16'h0000;
        m_cnt   = 5'd0;
    endtask

    task automatic do_write(input logic [3:0] off, input logic [31:0] data,
                            input logic [3:0] strb, input logic last);
        bus.wr_offset = off;
        bus.wr_data   = data;
        bus.wr_strb   = strb;
        bus.wr_last   = last;
        bus.wr_valid  = 1'b1;
        check("wr_ready", 512'(bus.wr_ready), 512'(1'b1));
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (!STRB_EN || strb[b]) m_line[off][8*b +: 8] = data[8*b +: 8];
        end
        m_dirty[off] = 1'b1;
        if (m_cnt != 5'd31) m_cnt = m_cnt + 5'd1;
        if (last) sb_q.push_back('{m_pack(), m_dirty, m_cnt, 1'b0});
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_ld_ready", 512'(bus.ld_ready), 512'(1'b1));
        check("idle_out_valid", 512'(bus.out_valid), 512'(1'b0));
    endtask

    task automatic b12_write(input logic [3:0] off, input logic [31:0] data, input logic last);
        b12.wr_offset = off;
        b12.wr_data   = data;
        b12.wr_strb   = 4'hF;
        b12.wr_last   = last;
        b12.wr_valid  = 1'b1;
        tick();
        b12.wr_valid = 1'b0;
        b12.wr_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        {bus.ld_valid, bus.wr_valid, bus.wr_last, bus.out_ready} = 4'b0000;
        {b12.ld_valid, b12.wr_valid, b12.wr_last, b12.out_ready} = 4'b0000;
        bus.ld_data = '0; bus.wr_offset = 4'd0; bus.wr_data = 32'd0; bus.wr_strb = 4'h0;
        b12.ld_data = '0; b12.wr_offset = 4'd0; b12.wr_data = 32'd0; b12.wr_strb = 4'h0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_ld_ready", 512'(bus.ld_ready), 512'(1'b1));
        check("rst_wr_ready", 512'(bus.wr_ready), 512'(1'b0));
        check("rst_out_valid", 512'(bus.out_valid), 512'(1'b0));
        check("rst_dirty", 512'(bus.out_dirty), 512'(16'h0000));
        check("rst_count", 512'(bus.out_wr_count), 512'(5'd0));
        check("rst_err", 512'(bus.out_err), 512'(1'b0));
        check("rst_line", bus.out_data, 512'd0);

        // Basic merge and load-to-output latency
        do_load(blk_idx());
        check("lat_early_valid", 512'(bus.out_valid), 512'(1'b0));
        do_write(4'd3, 32'hDEADBEEF, 4'hF, 1'b1);
        check("lat_out_valid", 512'(bus.out_valid), 512'(1'b1));
        check("out_ld_ready", 512'(bus.ld_ready), 512'(1'b0));
        check("t1_word3", 512'(bus.out_data[3*32 +: 32]), 512'(32'hDEADBEEF));
        check("t1_word2", 512'(bus.out_data[2*32 +: 32]), 512'(32'h00000002));
        check("t1_dirty", 512'(bus.out_dirty), 512'(16'h0008));
        check("t1_count", 512'(bus.out_wr_count), 512'(5'd1));
        release_out();

        // Byte strobes, then accumulation into the same word
        do_load(blk_fill(32'h11111111));
        do_write(4'd0, 32'hAABBCCDD, 4'h5, 1'b0);
        check("t2_word0_first", 512'(bus.out_data[31:0]), 512'(STRB_EN ? 32'h11BB11DD : 32'hAABBCCDD));
        do_write(4'd0, 32'h22334455, 4'h2, 1'b1);
        check("t2_word0_accum", 512'(bus.out_data[31:0]), 512'(STRB_EN ? 32'h11BB44DD : 32'h22334455));
        check("t2_dirty", 512'(bus.out_dirty), 512'(16'h0001));
        release_out();

        // Multi-write with a repeat to word 15 and a zero-strobe write to word 7
        do_load(blk_idx());
        do_write(4'd15, 32'h12345678, 4'hF, 1'b0);
        do_write(4'd7, 32'hFFFFFFFF, 4'h0, 1'b0);
        do_write(4'd0, 32'hCAFEF00D, 4'hF, 1'b0);
        do_write(4'd15, 32'h9ABCDEF0, 4'hF, 1'b1);
        check("t3_word15", 512'(bus.out_data[15*32 +: 32]), 512'(32'h9ABCDEF0));
        check("t3_word7", 512'(bus.out_data[7*32 +: 32]), 512'(STRB_EN ? 32'h00000007 : 32'hFFFFFFFF));
        check("t3_dirty", 512'(bus.out_dirty), 512'(16'h8081));
        check("t3_count", 512'(bus.out_wr_count), 512'(5'd4));
        release_out();

        // Backpressure with a pending load that must wait for IDLE
        do_load(blk_fill(32'hA5A5A5A5));
        do_write(4'd9, 32'h01020304, 4'hF, 1'b1);
        snap = m_pack();
        bus.ld_data  = blk_fill(32'h5A5A5A5A);
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 512'(bus.out_valid), 512'(1'b1));
            check("bp_ld_ready", 512'(bus.ld_ready), 512'(1'b0));
            check("bp_data_stable", bus.out_data, snap);
            check("bp_count_stable", 512'(bus.out_wr_count), 512'(5'd1));
            tick();
        end
        release_out();
        check("bp_no_load_in_out", 512'(bus.wr_ready), 512'(1'b0));
        do_load(blk_fill(32'h5A5A5A5A));
        check("bp_load_taken", 512'(bus.wr_ready), 512'(1'b1));
        do_write(4'd1, 32'h00000000, 4'hF, 1'b1);
        release_out();

        // Write count saturation
        do_load(blk_idx());
        for (int i = 0; i < 40; i++) begin
            do_write(4'(i % 16), 32'(i) + 32'h100, 4'hF, (i == 39));
        end
        check("sat_count", 512'(bus.out_wr_count), 512'(5'd31));
        check("sat_dirty", 512'(bus.out_dirty), 512'(16'hFFFF));
        release_out();

        // Reset in the middle of a merge
        do_load(blk_idx());
        do_write(4'd2, 32'h11112222, 4'hF, 1'b0);
        do_write(4'd5, 32'h33334444, 4'hF, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ld_ready", 512'(bus.ld_ready), 512'(1'b1));
        check("mrst_wr_ready", 512'(bus.wr_ready), 512'(1'b0));
        check("mrst_dirty", 512'(bus.out_dirty), 512'(16'h0000));
        check("mrst_count", 512'(bus.out_wr_count), 512'(5'd0));
        do_load(blk_fill(32'h0F0F0F0F));
        do_write(4'd4, 32'hBEEF0000, 4'hC, 1'b1);
        check("mrst_word4", 512'(bus.out_data[4*32 +: 32]), 512'(STRB_EN ? 32'hBEEF0F0F : 32'hBEEF0000));
        check("mrst_dirty_after", 512'(bus.out_dirty), 512'(16'h0010));
        release_out();

        // 12-word instance: offsets 13 and 12 are out of range
        for (int k = 0; k < 12; k++) blk12[k*32 +: 32] = 32'(k) + 32'h100;
        b12.ld_data  = blk12;
        b12.ld_valid = 1'b1;
        check("e12_ld_ready", 512'(b12.ld_ready), 512'(1'b1));
        tick();
        b12.ld_valid = 1'b0;
        b12_write(4'd13, 32'hFFFFFFFF, 1'b0);
        check("e12_err_mid", 512'(b12.out_err), 512'(1'b1));
        b12_write(4'd12, 32'hEEEEEEEE, 1'b0);
        b12_write(4'd11, 32'h0000BEEF, 1'b1);
        e12 = blk12;
        e12[11*32 +: 32] = 32'h0000BEEF;
        check("e12_out_valid", 512'(b12.out_valid), 512'(1'b1));
        check("e12_err", 512'(b12.out_err), 512'(1'b1));
        check("e12_count", 512'(b12.out_wr_count), 512'(5'd3));
        check("e12_dirty", 512'(b12.out_dirty), 512'(12'h800));
        check("e12_data", 512'(b12.out_data), 512'(e12));
        b12.out_ready = 1'b1;
        tick();
        b12.out_ready = 1'b0;
        b12.ld_valid  = 1'b1;
        tick();
        b12.ld_valid = 1'b0;
        b12_write(4'd0, 32'h00000001, 1'b1);
        check("e12_err_cleared", 512'(b12.out_err), 512'(1'b0));
        check("e12_count2", 512'(b12.out_wr_count), 512'(5'd1));
        b12.out_ready = 1'b1;
        tick();
        b12.out_ready = 1'b0;

        tick();
        check("sb_drained", 512'(sb_q.size()), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
